// File: rtl/alu_pkg.sv
// alu_pkg -- definitions shared by the ALU and its writeback stage.
//   OP_*         6-bit ALU control codes
//   flags_t      packed {N,Z,C,V} status word
//   is_legal     true for codes the writeback stage will commit
//   sets_flags   true for codes whose ALU flags become architectural
package alu_pkg;

   localparam logic [5:0] OP_ADD = 6'b000001;
   localparam logic [5:0] OP_SUB = 6'b000010;
   localparam logic [5:0] OP_DIV = 6'b000100;
   localparam logic [5:0] OP_MUL = 6'b000101;
   localparam logic [5:0] OP_AND = 6'b000110;
   localparam logic [5:0] OP_OR  = 6'b000111;

   typedef struct packed {
      logic N;
      logic Z;
      logic C;
      logic V;
   } flags_t;

   function automatic logic is_legal(input logic [5:0] code);
      return (code == OP_ADD) || (code == OP_SUB) || (code == OP_DIV) ||
             (code == OP_MUL) || (code == OP_AND) || (code == OP_OR);
   endfunction

   // Only the adder produces meaningful flags; the other units leave
   // their flag outputs undefined.
   function automatic logic sets_flags(input logic [5:0] code);
      return (code == OP_ADD) || (code == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// alu_writeback_if -- bundle between the ALU side, the writeback stage and
// the register-file write port.
//   flush                          discard buffered results
//   in_valid/in_ready              ALU result handshake
//   in_control/in_result/in_N..V   ALU control code, salida and flags
//   in_rd                          destination register index
//   out_valid/out_ready            register-file write handshake
//   out_result/out_rd              head-of-queue result and destination
//   flags                          architectural {N,Z,C,V}
//   err_cnt                        saturating count of illegal codes
// master = producer/consumer side (ALU + register file), slave = stage.
interface alu_writeback_if #(
   parameter int n  = 32,
   parameter int RW = 4
);
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [5:0]    in_control;
   logic [n-1:0]  in_result;
   logic          in_N;
   logic          in_Z;
   logic          in_C;
   logic          in_V;
   logic [RW-1:0] in_rd;
   logic          out_valid;
   logic          out_ready;
   logic [n-1:0]  out_result;
   logic [RW-1:0] out_rd;
   logic [3:0]    flags;
   logic [7:0]    err_cnt;

   modport master (
      output flush, in_valid, in_control, in_result, in_N, in_Z, in_C, in_V,
             in_rd, out_ready,
      input  in_ready, out_valid, out_result, out_rd, flags, err_cnt
   );

   modport slave (
      input  flush, in_valid, in_control, in_result, in_N, in_Z, in_C, in_V,
             in_rd, out_ready,
      output in_ready, out_valid, out_result, out_rd, flags, err_cnt
   );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with synchronous flush.
//   clk, rst_n   clock, synchronous active-low reset (also clears storage)
//   flush        empty the FIFO next edge; voids push and pop this cycle
//   push, wdata  write request (ignored when full)
//   pop          read request (ignored when empty)
//   rdata        head entry (storage output, no bypass)
//   count        occupancy, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count < FULL) && !flush;
   assign do_pop  = pop && (count != '0) && !flush;
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback -- ALU writeback stage: buffers ALU results for the
// register file and holds the architectural NZCV register.
//   clk, rst_n   clock, synchronous active-low reset
//   wb (slave)   flush, ALU result input handshake, register-file output
//                handshake, flags and err_cnt status (see alu_writeback_if)
// Parameters n and RW must match those of the connected interface.
module alu_writeback
   import alu_pkg::*;
#(
   parameter int n     = 32,
   parameter int DEPTH = 2,
   parameter int RW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_writeback_if.slave wb
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [CW-1:0]     count;
   logic [n+RW-1:0]   head;
   logic              accept;
   logic              push;
   flags_t            flags_q;
   logic [7:0]        err_q;

   // in_ready looks only at occupancy and flush, so no in_* -> out_* path
   // and no dependence on out_ready (a full FIFO never passes through).
   assign wb.in_ready = !wb.flush && (count < FULL);
   assign accept      = wb.in_valid && wb.in_ready;
   assign push        = accept && is_legal(wb.in_control);

   sync_fifo #(
      .WIDTH (n + RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (wb.flush),
      .push  (push),
      .wdata ({wb.in_result, wb.in_rd}),
      .pop   (wb.out_ready),
      .rdata (head),
      .count (count)
   );

   assign wb.out_valid = (count != '0);
   assign {wb.out_result, wb.out_rd} = head;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_q <= '0;
         err_q   <= '0;
      end else if (accept) begin
         if (sets_flags(wb.in_control))
            flags_q <= {wb.in_N, wb.in_Z, wb.in_C, wb.in_V};
         if (!is_legal(wb.in_control) && (err_q != 8'hFF))
            err_q <= err_q + 8'd1;
      end
   end

   assign wb.flags   = flags_q;
   assign wb.err_cnt = err_q;
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback -- directed bench for alu_writeback with a queue-based
// reference model checked every cycle plus literal expectations.
module tb_alu_writeback;
   localparam int N_W   = 32;
   localparam int DEPTH = 2;
   localparam int RW    = 4;

   logic clk;
   logic rst_n;
   logic run;
   int   nchk;
   int   nerr;

   alu_writeback_if #(.n(N_W), .RW(RW)) wb ();

   alu_writeback #(.n(N_W), .DEPTH(DEPTH), .RW(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [N_W+RW-1:0] mq[$];
   logic [3:0]        mflags;
   int                merr;

   function automatic logic m_legal(input logic [5:0] c);
      case (c)
         6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   always @(posedge clk) begin
      int   sz;
      logic acc;
      sz = mq.size();
      if (!rst_n) begin
         mq.delete();
         mflags = 4'b0000;
         merr   = 0;
      end else if (wb.flush) begin
         mq.delete();
      end else begin
         acc = wb.in_valid && (sz < DEPTH);
         if (sz != 0 && wb.out_ready) void'(mq.pop_front());
         if (acc) begin
            if (m_legal(wb.in_control)) begin
               mq.push_back({wb.in_result, wb.in_rd});
               if (wb.in_control == 6'd1 || wb.in_control == 6'd2)
                  mflags = {wb.in_N, wb.in_Z, wb.in_C, wb.in_V};
            end else if (merr < 255) begin
               merr++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         chk("in_ready", {63'd0, wb.in_ready}, {63'd0, (!wb.flush && mq.size() < DEPTH)});
         chk("out_valid", {63'd0, wb.out_valid}, {63'd0, (mq.size() != 0)});
         if (mq.size() != 0)
            chk("head", {28'd0, wb.out_result, wb.out_rd}, {28'd0, mq[0]});
         chk("flags", {60'd0, wb.flags}, {60'd0, mflags});
         chk("err_cnt", {56'd0, wb.err_cnt}, 64'(merr));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] c, input logic [31:0] r,
                        input logic [3:0] f, input logic [3:0] rd);
      wb.in_valid   = v;
      wb.in_control = c;
      wb.in_result  = r;
      {wb.in_N, wb.in_Z, wb.in_C, wb.in_V} = f;
      wb.in_rd      = rd;
   endtask

   initial begin
      nchk = 0;
      nerr = 0;
      run  = 1'b0;
      rst_n = 1'b0;
      wb.flush = 1'b0;
      wb.out_ready = 1'b0;
      drive(1'b0, 6'd0, 32'd0, 4'b0000, 4'd0);
      @(posedge clk);
      run = 1'b1;
      #1;
      step();
      chk("rst_out_valid", {63'd0, wb.out_valid}, 64'd0);
      chk("rst_out_result", {32'd0, wb.out_result}, 64'd0);
      chk("rst_out_rd", {60'd0, wb.out_rd}, 64'd0);
      chk("rst_flags", {60'd0, wb.flags}, 64'd0);
      chk("rst_err_cnt", {56'd0, wb.err_cnt}, 64'd0);
      rst_n = 1'b1;
      step();

      // ADD 5 + (-5): result 0, Z=1 C=1
      drive(1'b1, 6'b000001, 32'd0, 4'b0101, 4'd3);
      step();
      drive(1'b0, 6'd0, 32'd0, 4'b0000, 4'd0);
      chk("add_out_valid", {63'd0, wb.out_valid}, 64'd1);
      chk("add_out_result", {32'd0, wb.out_result}, 64'd0);
      chk("add_out_rd", {60'd0, wb.out_rd}, 64'd3);
      chk("add_flags", {60'd0, wb.flags}, 64'h5);
      wb.out_ready = 1'b1;
      step();
      wb.out_ready = 1'b0;

      // SUB with N=1, then AND with flags driven 0000
      drive(1'b1, 6'b000010, 32'hFFFF_FFFF, 4'b1000, 4'd1);
      step();
      chk("sub_flags", {60'd0, wb.flags}, 64'h8);
      drive(1'b1, 6'b000110, 32'h0000_000F, 4'b0000, 4'd2);
      step();
      drive(1'b0, 6'd0, 32'd0, 4'b0000, 4'd0);
      chk("and_flags", {60'd0, wb.flags}, 64'h8);
      chk("sub_head_result", {32'd0, wb.out_result}, 64'hFFFF_FFFF);
      chk("sub_head_rd", {60'd0, wb.out_rd}, 64'd1);
      wb.out_ready = 1'b1;
      step();
      chk("and_head_result", {32'd0, wb.out_result}, 64'h0F);
      chk("and_head_rd", {60'd0, wb.out_rd}, 64'd2);
      step();
      chk("drained", {63'd0, wb.out_valid}, 64'd0);
      wb.out_ready = 1'b0;

      // Back-pressure: three MULs into a two-entry FIFO
      drive(1'b1, 6'b000101, 32'd100, 4'b1111, 4'd10);
      step();
      drive(1'b1, 6'b000101, 32'd101, 4'b1111, 4'd11);
      step();
      drive(1'b1, 6'b000101, 32'd102, 4'b1111, 4'd12);
      chk("full_in_ready", {63'd0, wb.in_ready}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_head", {32'd0, wb.out_result}, 64'd100);
         step();
      end
      wb.out_ready = 1'b1;
      step();
      chk("after_pop_in_ready", {63'd0, wb.in_ready}, 64'd1);
      chk("after_pop_head", {32'd0, wb.out_result}, 64'd101);
      step();
      drive(1'b0, 6'd0, 32'd0, 4'b0000, 4'd0);
      chk("third_head", {32'd0, wb.out_result}, 64'd102);
      step();
      step();

      // Sustained throughput: MUL 1..10 with out_ready held high
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 6'b000101, 32'(i), 4'b0110, 4'(i));
         chk("stream_in_ready", {63'd0, wb.in_ready}, 64'd1);
         step();
         chk("stream_head", {32'd0, wb.out_result}, 64'(i));
      end
      drive(1'b0, 6'd0, 32'd0, 4'b0000, 4'd0);
      step();
      step();

      // Illegal code 300 times
      drive(1'b1, 6'b111111, 32'hDEAD_BEEF, 4'b1111, 4'd7);
      for (int i = 0; i < 300; i++) step();
      drive(1'b0, 6'd0, 32'd0, 4'b0000, 4'd0);
      chk("illegal_err_sat", {56'd0, wb.err_cnt}, 64'd255);
      chk("illegal_no_push", {63'd0, wb.out_valid}, 64'd0);
      chk("illegal_flags", {60'd0, wb.flags}, 64'h8);

      // Flush with two entries buffered and in_valid high
      wb.out_ready = 1'b0;
      drive(1'b1, 6'b000111, 32'd7, 4'b1111, 4'd5);
      step();
      drive(1'b1, 6'b000111, 32'd8, 4'b1111, 4'd6);
      step();
      drive(1'b1, 6'b000001, 32'd9, 4'b1111, 4'd4);
      wb.flush = 1'b1;
      #1;
      chk("flush_in_ready", {63'd0, wb.in_ready}, 64'd0);
      step();
      wb.flush = 1'b0;
      drive(1'b0, 6'd0, 32'd0, 4'b0000, 4'd0);
      chk("flush_out_valid", {63'd0, wb.out_valid}, 64'd0);
      chk("flush_flags", {60'd0, wb.flags}, 64'h8);
      chk("flush_err_cnt", {56'd0, wb.err_cnt}, 64'd255);
      step();

      // Reset in the middle of traffic
      drive(1'b1, 6'b000001, 32'h55, 4'b0011, 4'd9);
      step();
      chk("pre_rst_flags", {60'd0, wb.flags}, 64'h3);
      drive(1'b1, 6'b000010, 32'h66, 4'b1001, 4'd8);
      wb.out_ready = 1'b1;
      rst_n = 1'b0;
      step();
      chk("mid_rst_out_valid", {63'd0, wb.out_valid}, 64'd0);
      chk("mid_rst_out_result", {32'd0, wb.out_result}, 64'd0);
      chk("mid_rst_out_rd", {60'd0, wb.out_rd}, 64'd0);
      chk("mid_rst_flags", {60'd0, wb.flags}, 64'd0);
      chk("mid_rst_err_cnt", {56'd0, wb.err_cnt}, 64'd0);
      rst_n = 1'b1;
      drive(1'b0, 6'd0, 32'd0, 4'b0000, 4'd0);
      step();
      step();

      run = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the ALU. Each cycle it can capture one ALU result (`salida`) with its N/Z/C/V flags, control code and destination register index. Results are buffered in a small FIFO and released to the register-file write port over a valid/ready handshake. It also holds the architectural NZCV status register, which is updated only by add and subtract operations.

## Interface

Parameters:
- `n`, 32, datapath width; must match the ALU.
- `DEPTH`, 2, result FIFO entries; power of two, ≥2.
- `RW`, 4, destination register index width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `flush`  in  1  discard all buffered results.
- `in_valid`  in  1  ALU result present.
- `in_ready`  out  1  stage can accept.
- `in_control`  in  6  ALU control code of this result.
- `in_result`  in  n  ALU `salida`.
- `in_N`, `in_Z`, `in_C`, `in_V`  in  1 each  ALU flags.
- `in_rd`  in  RW  destination register.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  register file accepts the head.
- `out_result`  out  n  head result.
- `out_rd`  out  RW  head destination.
- `flags`  out  4  architectural {N,Z,C,V}.
- `err_cnt`  out  8  count of illegal control codes, saturating.

## Operation

- Accept: `in_valid && in_ready`.
- `in_ready = !flush && (count < DEPTH)`. There is no pass-through: a full FIFO blocks input even when `out_ready` is high.
- Legal codes: 000001 ADD, 000010 SUB, 000100 DIV, 000101 MUL, 000110 AND, 000111 OR.
- Accepted legal code: push {result, rd} into the FIFO.
- Accepted ADD/SUB: `flags <= {in_N,in_Z,in_C,in_V}` as well.
- Accepted DIV/MUL/AND/OR: flags are unchanged. The ALU flag outputs are not meaningful for these codes and must be ignored.
- Accepted illegal code: not pushed, flags unchanged, `err_cnt` increments and saturates at 255.
- Pop: `out_valid && out_ready` removes the head. `out_valid = (count != 0)`.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- `flush`:
  - Next cycle count = 0 and pointers = 0.
  - Any pop in the same cycle is void.
  - Input is blocked for that cycle (`in_ready` = 0).
  - Flags and `err_cnt` are preserved.
- Reset (`rst_n` = 0 at an edge):
  - count, pointers, `flags`, `err_cnt` = 0.
  - `out_valid` = 0.
  - `out_result`/`out_rd` = 0 (storage is cleared).
  - Reset overrides flush and all handshakes. A transfer in progress is lost.

## Timing

- Latency from accept at edge k: `out_valid` high after edge k when the FIFO was empty.
- `flags` show the new value after edge k.
- The head is stable while `out_valid && !out_ready`. `out_valid` never drops without a pop, flush or reset.
- Throughput: one result per cycle sustained when `out_ready` is held high.
- All outputs are registered or derived from count/head storage only. There is no combinational path from any `in_*` port to any `out_*` port.
- `in_ready` depends only on count and `flush`, not on `out_ready`.

## Structure

- Shared package `alu_pkg`:
  - Control code constants `OP_ADD`, `OP_SUB`, `OP_DIV`, `OP_MUL`, `OP_AND`, `OP_OR` (6 bits); the ALU is to be migrated onto the same constants.
  - `typedef struct packed {logic N,Z,C,V;} flags_t`.
- One sub-module `sync_fifo` (params WIDTH, DEPTH): storage, pointers, count, push/pop/flush. Instantiated with WIDTH = n+RW.
- Top level: decode, flag register, error counter.

## Test plan

- Reset then ADD 5+(−5): `in_result`=0, Z=1, C=1, rd=3. Expect `out_valid` next cycle with result 0, rd 3, and `flags`=0101.
- SUB (N=1) then AND with ALU flags driven to 0000. Expect `flags`=1000 after the SUB, still 1000 after the AND, and both results delivered in order.
- `out_ready`=0 with DEPTH=2: push three back-to-back. Expect `in_ready` to drop after two, the third held off until one pop, and head data stable throughout the stall.
- `out_ready`=1 with continuous valid MUL results 1..10. Expect one output per cycle, in order, with `in_ready` never low.
- Illegal code 6'b111111 sent 300 times. Expect no FIFO entries, flags unchanged, and `err_cnt` stuck at 255.
- Two entries buffered, then `flush` together with `in_valid`=1. Expect `in_ready`=0 in that cycle, `out_valid`=0 next cycle, and flags retained. Assert `rst_n`=0 mid-stream: all outputs 0 after the edge.
